// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer.
//   - instruction field positions within the 8-bit instruction word
//   - op encodings (ADD/SUB/AND/MOV)
//   - FSM state encoding
package regfile_sequencer_pkg;

  localparam int INSTR_W = 8;

  // instr = {op[7:6], rs[5:4], rt[3:2], rd[1:0]}
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 2;
  localparam int RD_MSB = 1;
  localparam int RD_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MOV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  function automatic op_e instr_op(input logic [INSTR_W-1:0] i);
    return op_e'(i[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/regfile_sequencer_alu.sv
// seq_alu: combinational ALU for the sequencer.
//   op          : operation select
//   a, b        : operands
//   result      : DATA_W-bit wrap-around result
//   carry       : carry out (ADD) or borrow (SUB)
//   carry_valid : 1 when this op updates the carry flag
module seq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              carry_valid
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit on each: the top bit is the carry for ADD and the
  // borrow (a < b) for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result      = '0;
    carry       = 1'b0;
    carry_valid = 1'b0;
    case (op)
      OP_ADD: begin
        result      = sum[DATA_W-1:0];
        carry       = sum[DATA_W];
        carry_valid = 1'b1;
      end
      OP_SUB: begin
        result      = diff[DATA_W-1:0];
        carry       = diff[DATA_W];
        carry_valid = 1'b1;
      end
      OP_AND:  result = a & b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: fetches one instruction at a time, reads two sources
// from an external register file, executes in seq_alu and writes back.
// Four-cycle loop IDLE -> READ -> EXEC -> WRITE -> IDLE.
//   clk, reset                  : clock, synchronous active-high reset
//   instr_valid/instr_ready     : instruction handshake (accept in IDLE)
//   instr                       : {op, rs, rt, rd}
//   read_register1/2, read_data1/2 : register-file read ports
//   write_register, write_data, reg_write : register-file write port
//   done  : one-cycle retire pulse (WRITE)
//   carry : carry/borrow of the last ADD/SUB
//   busy  : not IDLE
// Every output is a register or a decode of the state register.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  read_register1,
  output logic [ADDR_W-1:0]  read_register2,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  output logic [ADDR_W-1:0]  write_register,
  output logic [DATA_W-1:0]  write_data,
  output logic               reg_write,
  output logic               done,
  output logic               carry,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [DATA_W-1:0]    result_q;
  logic                 carry_q;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_c, alu_cv;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op          (instr_op(instr_q)),
    .a           (read_data1),
    .b           (read_data2),
    .result      (alu_res),
    .carry       (alu_c),
    .carry_valid (alu_cv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // instr is only captured on acceptance; changes while busy are ignored
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      if (state_q == EXEC) begin
        result_q <= alu_res;
        if (alu_cv) carry_q <= alu_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    reg_write   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_d = READ;
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register indices come straight from the latched instruction, so they
  // are stable from READ through WRITE and zero after reset.
  assign read_register1 = ADDR_W'(instr_q[RS_MSB:RS_LSB]);
  assign read_register2 = ADDR_W'(instr_q[RT_MSB:RT_LSB]);
  assign write_register = ADDR_W'(instr_q[RD_MSB:RD_LSB]);
  assign write_data     = result_q;
  assign carry          = carry_q;

endmodule
